axi_tagc_way_arbiter: RTL and testbench
=======================================

// Module: axi_tagc_way_arbiter
// PURPOSE
// Shares the single data-way SRAM port between NumUnits requesters (RChan, WChan, Evict, Refill units).
// Grants requests round-robin and forwards the winner to the data ways.
// Records the unit index of every read in an ordered route FIFO.
// Steers each returning way response back to the unit that issued it.
// PARAMETERS
// NumUnits    4          number of requesting units; index = axi_llc_pkg cache_unit encoding
// MaxOutst    4          max in-flight reads (route FIFO depth, power of 2, >=2)
// way_inp_t   logic      way request struct (has cache_unit, we, way_ind, line_addr, blk_offset, data)
// way_oup_t   logic      way response struct (has cache_unit, data)
// PORTS
// clk_i            in   1                clock, rising edge
// rst_ni           in   1                reset, synchronous, active-low
// unit_req_i       in   NumUnits x way_inp_t  per-unit request payload
// unit_valid_i     in   NumUnits         per-unit request valid
// unit_ready_o     out  NumUnits         per-unit request accepted
// way_inp_o        out  way_inp_t        request to data ways
// way_inp_valid_o  out  1                request valid
// way_inp_ready_i  in   1                data ways ready
// way_out_i        in   way_oup_t        response from data ways
// way_out_valid_i  in   1                response valid
// way_out_ready_o  out  1                response accepted
// unit_rsp_o       out  way_oup_t        response payload, broadcast to all units
// unit_rsp_valid_o out  NumUnits         one-hot response valid
// unit_rsp_ready_i in   NumUnits         per-unit response ready
// BEHAVIOUR
// - Single clock domain. Reset is synchronous, active-low.
// - Reset state: rr_ptr=0, lock=0, route FIFO empty, all valids/readies 0.
// - Eligible(i) = unit_valid_i[i] && (unit_req_i[i].we || !route_full).
//   Writes never need a route FIFO slot.
// - Arbitration: pick the first eligible unit at or after rr_ptr (wrap mod NumUnits).
// - Combinational grant. Zero-cycle latency from unit_valid_i to way_inp_valid_o.
// - way_inp_o = winner payload, with cache_unit overwritten by the winner index.
// - way_inp_valid_o = any eligible. unit_ready_o[win] = way_inp_ready_i. All other readies are 0.
// - Lock rule (AXI stability): if way_inp_valid_o=1 and way_inp_ready_i=0, latch lock=1 and the winner.
//   - While lock=1, the same winner is held even if a higher-priority unit raises valid.
//   - Lock clears on handshake.
// - Handshake (valid&ready):
//   - rr_ptr <= win+1 (wrap).
//   - If !we, push win into the route FIFO.
// - Responses:
//   - Head of the route FIFO selects the destination. unit_rsp_valid_o[head] = way_out_valid_i && !route_empty.
//   - way_out_ready_o = unit_rsp_ready_i[head] && !route_empty.
//   - Pop on way_out handshake.
//   - unit_rsp_o = way_out_i, with cache_unit replaced by head.
// - Simultaneous push+pop when full: push is gated by route_full in the same cycle.
//   Pop-then-push bypass is NOT allowed; this keeps the timing path short.
// - Simultaneous push+pop otherwise: occupancy unchanged, both pointers advance.
// - Response with route FIFO empty is a protocol error.
//   - way_out_ready_o=0, so the response is never accepted.
//   - Simulation assertion fires.
// - Reset mid-operation:
//   - In-flight route entries are discarded and the lock is cleared.
//   - Units and data ways are reset on the same rst_ni.
// - Assertions:
//   - Once asserted, way_inp_o is stable until handshake.
//   - unit_rsp_valid_o is onehot0.
//   - Route occupancy is <= MaxOutst.
// STRUCTURE
// - axi_llc_pkg holds: cache_unit encoding, NumUnits constant, way_inp_t/way_oup_t field definitions.
// - Sub-module axi_tagc_route_fifo: sync-reset FIFO of $clog2(NumUnits)-bit entries.
//   - Outputs: full/empty, head.
//   - Width: ptr $clog2(MaxOutst), count $clog2(MaxOutst)+1.
// - Top level contains only the round-robin pointer, lock flop and steering logic.
// TESTING
// - T1 single read:
//   - Stimulus: unit 0 read, way ready, response 2 cycles later.
//   - Required: grant in the same cycle; unit_rsp_valid_o=4'b0001; route empty afterwards.
// - T2 fairness:
//   - Stimulus: all 4 units valid continuously (reads), way always ready, responses returned.
//   - Required: grant order 0,1,2,3,0,...; no unit starves.
// - T3 lock:
//   - Stimulus: unit 2 valid, way_inp_ready_i=0 for 3 cycles, unit 1 raises valid at cycle 1.
//   - Required: winner stays 2 until handshake; unit 1 is granted next.
// - T4 route full:
//   - Stimulus: MaxOutst=4 reads accepted with no responses; unit 3 then issues a read and unit 1 a write.
//   - Required: the write is granted; the read is stalled until the first pop.
// - T5 response backpressure:
//   - Stimulus: response for unit 1 with unit_rsp_ready_i[1]=0 for 5 cycles.
//   - Required: way_out_ready_o=0; the FIFO head is unchanged; pop occurs on the ready cycle.
// - T6 reset mid-op:
//   - Stimulus: rst_ni=0 for 1 cycle with 3 outstanding reads and lock=1.
//   - Required: all outputs 0 next cycle; the next grant starts from unit 0.

Source files
------------

// File: rtl/axi_llc_pkg.sv
// Shared cache-unit encoding and data-way request/response structures for the LLC tag controller.
package axi_llc_pkg;

  localparam int unsigned NumUnits  = 4;
  localparam int unsigned UnitW     = $clog2(NumUnits);
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned WayIndW   = 2;
  localparam int unsigned LineAddrW = 8;
  localparam int unsigned BlkOffW   = 2;

  typedef enum logic [UnitW-1:0] {
    RChanUnit  = 2'd0,
    WChanUnit  = 2'd1,
    EvictUnit  = 2'd2,
    RefillUnit = 2'd3
  } cache_unit_e;

  typedef logic [UnitW-1:0] unit_idx_t;

  typedef struct packed {
    unit_idx_t             cache_unit;
    logic                  we;
    logic [WayIndW-1:0]    way_ind;
    logic [LineAddrW-1:0]  line_addr;
    logic [BlkOffW-1:0]    blk_offset;
    logic [DATA_W-1:0]     data;
  } way_inp_t;

  typedef struct packed {
    unit_idx_t             cache_unit;
    logic [DATA_W-1:0]     data;
  } way_oup_t;

  // Increment with wrap at n, used for round-robin pointers of any unit count.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/axi_tagc_route_fifo.sv
// Ordered record of which unit issued each in-flight data-way read; head names the
// destination of the next returning response.
module axi_tagc_route_fifo
  import axi_llc_pkg::*;
#(
  parameter int unsigned NumUnits = axi_llc_pkg::NumUnits,
  parameter int unsigned MaxOutst = 4,
  localparam int unsigned EntryW  = (NumUnits > 1) ? $clog2(NumUnits) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [EntryW-1:0] data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [EntryW-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(MaxOutst);
  localparam int unsigned CntW = PtrW + 1;

  logic [EntryW-1:0] mem_q [MaxOutst];
  logic [EntryW-1:0] mem_d [MaxOutst];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push_eff, pop_eff;

  assign full_o  = (count_q == CntW'(MaxOutst));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Push is gated by the current full flag even when a pop happens in the same cycle.
  always_comb begin
    push_eff = push_i && !full_o;
    pop_eff  = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_eff) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push_eff) - CntW'(pop_eff);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  a_occupancy: assert property (@(posedge clk_i) count_q <= CntW'(MaxOutst));

endmodule

// File: rtl/axi_tagc_way_arbiter.sv
// Round-robin arbiter sharing the data-way port among cache units, with response steering
// driven by the order in which reads were issued.
module axi_tagc_way_arbiter
  import axi_llc_pkg::*;
#(
  parameter int unsigned NumUnits = axi_llc_pkg::NumUnits,
  parameter int unsigned MaxOutst = 4,
  parameter type way_inp_t = axi_llc_pkg::way_inp_t,
  parameter type way_oup_t = axi_llc_pkg::way_oup_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  way_inp_t            unit_req_i [NumUnits],
  input  logic [NumUnits-1:0] unit_valid_i,
  output logic [NumUnits-1:0] unit_ready_o,
  output way_inp_t            way_inp_o,
  output logic                way_inp_valid_o,
  input  logic                way_inp_ready_i,
  input  way_oup_t            way_out_i,
  input  logic                way_out_valid_i,
  output logic                way_out_ready_o,
  output way_oup_t            unit_rsp_o,
  output logic [NumUnits-1:0] unit_rsp_valid_o,
  input  logic [NumUnits-1:0] unit_rsp_ready_i
);

  localparam int unsigned UnitW = (NumUnits > 1) ? $clog2(NumUnits) : 1;
  typedef logic [UnitW-1:0] idx_t;

  idx_t                rr_ptr_q, rr_ptr_d, lock_win_q, lock_win_d, win, head;
  logic                lock_q, lock_d;
  logic                route_full, route_empty, push, pop, inp_hs;
  logic [NumUnits-1:0] eligible;

  // Descending scan so the candidate closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    eligible        = '0;
    win             = rr_ptr_q;
    way_inp_valid_o = 1'b0;
    for (int i = 0; i < NumUnits; i++) begin
      eligible[i] = unit_valid_i[i] && (unit_req_i[i].we || !route_full);
    end
    if (lock_q) begin
      win             = lock_win_q;
      way_inp_valid_o = eligible[lock_win_q];
    end else begin
      for (int k = NumUnits - 1; k >= 0; k--) begin
        if (eligible[idx_t'((int'(rr_ptr_q) + k) % int'(NumUnits))]) begin
          win             = idx_t'((int'(rr_ptr_q) + k) % int'(NumUnits));
          way_inp_valid_o = 1'b1;
        end
      end
    end
    way_inp_o            = unit_req_i[win];
    way_inp_o.cache_unit = win;
    unit_ready_o         = '0;
    unit_ready_o[win]    = way_inp_valid_o && way_inp_ready_i;
    inp_hs               = way_inp_valid_o && way_inp_ready_i;
    push                 = inp_hs && !way_inp_o.we;
  end

  // A stalled grant is frozen until it completes so the request seen by the ways never changes.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_win_d = lock_win_q;
    if (inp_hs) begin
      rr_ptr_d = idx_t'(wrap_inc(32'(win), NumUnits));
      lock_d   = 1'b0;
    end else if (way_inp_valid_o) begin
      lock_d     = 1'b1;
      lock_win_d = win;
    end
  end

  always_comb begin
    unit_rsp_valid_o = '0;
    way_out_ready_o  = 1'b0;
    if (!route_empty) begin
      unit_rsp_valid_o[head] = way_out_valid_i;
      way_out_ready_o        = unit_rsp_ready_i[head];
    end
    unit_rsp_o            = way_out_i;
    unit_rsp_o.cache_unit = head;
    pop                   = way_out_valid_i && way_out_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_win_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_win_q <= lock_win_d;
    end
  end

  axi_tagc_route_fifo #(
    .NumUnits (NumUnits),
    .MaxOutst (MaxOutst)
  ) u_route_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (win),
    .pop_i   (pop),
    .full_o  (route_full),
    .empty_o (route_empty),
    .head_o  (head)
  );

  a_inp_stable: assert property (@(posedge clk_i)
    (rst_ni && way_inp_valid_o && !way_inp_ready_i) |=>
      (!rst_ni || (way_inp_valid_o && $stable(way_inp_o))));
  a_rsp_onehot: assert property (@(posedge clk_i) $onehot0(unit_rsp_valid_o));
  a_rsp_no_route: assert property (@(posedge clk_i) !(rst_ni && way_out_valid_i && route_empty));

endmodule

// File: tb/tb_axi_tagc_way_arbiter.sv
// Directed bench for the data-way arbiter: single read, fairness, lock, route-full,
// response backpressure and mid-operation reset.
module tb_axi_tagc_way_arbiter;
  import axi_llc_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  way_inp_t            req [NumUnits];
  logic [NumUnits-1:0] vld, uready, ursp_vld, ursp_rdy;
  way_inp_t            winp;
  logic                winp_vld, winp_rdy;
  way_oup_t            wout, ursp;
  logic                wout_vld, wout_rdy;
  int                  n_vec = 0;
  int                  n_err = 0;

  always #5 clk = ~clk;

  axi_tagc_way_arbiter #(
    .NumUnits (4),
    .MaxOutst (4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .unit_req_i       (req),
    .unit_valid_i     (vld),
    .unit_ready_o     (uready),
    .way_inp_o        (winp),
    .way_inp_valid_o  (winp_vld),
    .way_inp_ready_i  (winp_rdy),
    .way_out_i        (wout),
    .way_out_valid_i  (wout_vld),
    .way_out_ready_o  (wout_rdy),
    .unit_rsp_o       (ursp),
    .unit_rsp_valid_o (ursp_vld),
    .unit_rsp_ready_i (ursp_rdy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request payload carries a deliberately wrong cache_unit so the overwrite is visible.
  function automatic way_inp_t mk(input int u, input logic we);
    way_inp_t r;
    r.cache_unit = 2'(3 - u);
    r.we         = we;
    r.way_ind    = 2'(u);
    r.line_addr  = 8'(8'h40 + u);
    r.blk_offset = 2'(u + 1);
    r.data       = 32'hC0DE_0000 + 32'(u);
    return r;
  endfunction

  function automatic way_inp_t exp_inp(input int u, input logic we);
    way_inp_t r;
    r            = mk(u, we);
    r.cache_unit = 2'(u);
    return r;
  endfunction

  initial begin
    rst_n    = 1'b0;
    vld      = '0;
    winp_rdy = 1'b0;
    wout_vld = 1'b0;
    wout     = '0;
    ursp_rdy = '0;
    for (int i = 0; i < NumUnits; i++) req[i] = mk(i, 1'b0);

    // Reset state
    tick;
    tick;
    settle;
    chk("rst_inp_vld", 64'(winp_vld), 64'h0);
    chk("rst_uready", 64'(uready), 64'h0);
    chk("rst_rsp_vld", 64'(ursp_vld), 64'h0);
    rst_n    = 1'b1;
    ursp_rdy = 4'hF;
    settle;
    chk("rst_out_rdy_empty", 64'(wout_rdy), 64'h0);

    // T1 single read
    tick;
    vld      = 4'b0001;
    winp_rdy = 1'b1;
    settle;
    chk("t1_inp_vld", 64'(winp_vld), 64'h1);
    chk("t1_uready", 64'(uready), 64'h1);
    chk("t1_payload", 64'(winp), 64'(exp_inp(0, 1'b0)));
    tick;
    vld = '0;
    settle;
    chk("t1_route_busy", 64'(wout_rdy), 64'h1);
    tick;
    wout_vld = 1'b1;
    wout     = '{cache_unit: 2'd3, data: 32'h1111_0001};
    settle;
    chk("t1_rsp_vld", 64'(ursp_vld), 64'h1);
    chk("t1_rsp_unit", 64'(ursp.cache_unit), 64'h0);
    chk("t1_rsp_data", 64'(ursp.data), 64'h1111_0001);
    tick;
    wout_vld = 1'b0;
    settle;
    chk("t1_route_empty", 64'(wout_rdy), 64'h0);

    // T2 fairness, starting from a fresh reset
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    vld   = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        wout_vld = 1'b1;
        wout     = '{cache_unit: 2'd0, data: 32'h2000_0000 + 32'(k)};
      end
      settle;
      chk("t2_grant", 64'(uready), 64'(1) << (k % 4));
      if (k > 0) chk("t2_rsp", 64'(ursp_vld), 64'(1) << ((k - 1) % 4));
      tick;
    end
    vld = '0;
    settle;
    chk("t2_rsp_last", 64'(ursp_vld), 64'h8);
    tick;
    wout_vld = 1'b0;

    // T3 lock
    vld      = 4'b0100;
    winp_rdy = 1'b0;
    settle;
    chk("t3_c0_vld", 64'(winp_vld), 64'h1);
    chk("t3_c0_uready", 64'(uready), 64'h0);
    chk("t3_c0_unit", 64'(winp.cache_unit), 64'h2);
    tick;
    vld = 4'b0110;
    settle;
    chk("t3_c1_unit", 64'(winp.cache_unit), 64'h2);
    chk("t3_c1_payload", 64'(winp), 64'(exp_inp(2, 1'b0)));
    tick;
    settle;
    chk("t3_c2_unit", 64'(winp.cache_unit), 64'h2);
    tick;
    winp_rdy = 1'b1;
    settle;
    chk("t3_hs_uready", 64'(uready), 64'h4);
    tick;
    vld = 4'b0010;
    settle;
    chk("t3_next_uready", 64'(uready), 64'h2);
    chk("t3_next_unit", 64'(winp.cache_unit), 64'h1);
    tick;
    vld      = '0;
    wout_vld = 1'b1;
    wout     = '{cache_unit: 2'd0, data: 32'h3333_0002};
    settle;
    chk("t3_rsp_u2", 64'(ursp_vld), 64'h4);
    tick;
    settle;
    chk("t3_rsp_u1", 64'(ursp_vld), 64'h2);
    tick;
    wout_vld = 1'b0;

    // T4 route full: reads from 1,0,0,0 fill the route FIFO
    vld = 4'b0010;
    settle;
    chk("t4_rd_u1", 64'(uready), 64'h2);
    tick;
    vld = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      settle;
      chk("t4_rd_u0", 64'(uready), 64'h1);
      tick;
    end
    vld    = 4'b1010;
    req[1] = mk(1, 1'b1);
    settle;
    chk("t4_wr_uready", 64'(uready), 64'h2);
    chk("t4_wr_we", 64'(winp.we), 64'h1);
    chk("t4_wr_unit", 64'(winp.cache_unit), 64'h1);
    tick;
    vld = 4'b1000;
    settle;
    chk("t4_stall_vld", 64'(winp_vld), 64'h0);
    chk("t4_stall_u3", 64'(uready[3]), 64'h0);
    tick;

    // T5 response backpressure on head unit 1
    wout_vld = 1'b1;
    wout     = '{cache_unit: 2'd0, data: 32'h5555_0001};
    ursp_rdy = 4'b1101;
    for (int j = 0; j < 5; j++) begin
      settle;
      chk("t5_out_rdy", 64'(wout_rdy), 64'h0);
      chk("t5_head", 64'(ursp_vld), 64'h2);
      chk("t5_rd_stall", 64'(winp_vld), 64'h0);
      tick;
    end
    ursp_rdy = 4'hF;
    settle;
    chk("t5_pop_rdy", 64'(wout_rdy), 64'h1);
    chk("t5_no_bypass", 64'(winp_vld), 64'h0);
    tick;
    wout_vld = 1'b0;
    settle;
    chk("t4_rd_released", 64'(uready), 64'h8);
    chk("t4_rd_unit", 64'(winp.cache_unit), 64'h3);
    tick;

    // T6 reset with three outstanding reads and a held lock
    vld      = '0;
    wout_vld = 1'b1;
    settle;
    chk("t6_pop_u0", 64'(ursp_vld), 64'h1);
    tick;
    wout_vld = 1'b0;
    vld      = 4'b0010;
    settle;
    chk("t6_wr_uready", 64'(uready), 64'h2);
    tick;
    vld      = 4'b0100;
    winp_rdy = 1'b0;
    settle;
    chk("t6_lock_vld", 64'(winp_vld), 64'h1);
    chk("t6_lock_unit", 64'(winp.cache_unit), 64'h2);
    tick;
    rst_n = 1'b0;
    vld   = '0;
    tick;
    rst_n    = 1'b1;
    winp_rdy = 1'b1;
    settle;
    chk("t6_post_inp_vld", 64'(winp_vld), 64'h0);
    chk("t6_post_uready", 64'(uready), 64'h0);
    chk("t6_post_rsp_vld", 64'(ursp_vld), 64'h0);
    chk("t6_post_route_empty", 64'(wout_rdy), 64'h0);
    tick;
    req[1] = mk(1, 1'b0);
    vld    = 4'hF;
    settle;
    chk("t6_first_grant", 64'(uready), 64'h1);
    chk("t6_first_unit", 64'(winp.cache_unit), 64'h0);
    tick;
    vld = '0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
